// File: rtl/gost89_pkg.sv
// GOST 28147-89 shared types, constants and key schedule.
// Used by the CFB decryptor and the ECB cores.
package gost89_pkg;

   typedef logic [63:0]  block_t;
   typedef logic [31:0]  word_t;
   typedef logic [255:0] key_t;
   typedef logic [511:0] sbox_t;
   typedef logic [4:0]   rnd_t;

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   localparam int   ROUNDS   = 32;
   localparam int   ROT      = 11;
   localparam rnd_t LAST_RND = 5'(ROUNDS - 1);

   // Rounds 24..31 walk the key words backwards: 7 - (rnd mod 8).
   function automatic logic [2:0] key_index(input rnd_t rnd);
      return (rnd < 5'd24) ? rnd[2:0] : ~rnd[2:0];
   endfunction

   function automatic word_t rol(input word_t x);
      return (x << ROT) | (x >> (32 - ROT));
   endfunction

endpackage

// File: rtl/gost89_cfb_decrypt_if.sv
// Block-level bus of the GOST CFB decryptor.
// master drives strobes and data, slave returns result.
interface gost89_cfb_decrypt_if;
   import gost89_pkg::*;

   logic   load_iv;
   block_t iv;
   sbox_t  sbox;
   key_t   key;
   logic   load_data;
   block_t in;
   block_t out;
   logic   out_valid;
   logic   busy;

   modport master (
      output load_iv, iv, sbox, key, load_data, in,
      input  out, out_valid, busy
   );

   modport slave (
      input  load_iv, iv, sbox, key, load_data, in,
      output out, out_valid, busy
   );

endinterface

// File: rtl/gost89_round.sv
// One combinational GOST 28147-89 round on N = {N2, N1}.
// The last round writes T into N2 and keeps N1 (no swap).
module gost89_round
   import gost89_pkg::*;
(
   input  block_t i_n,
   input  word_t  i_k,
   input  sbox_t  i_sbox,
   input  logic   i_last,
   output block_t o_n
);

   word_t w_n1;
   word_t w_n2;
   word_t w_sum;
   word_t w_sub;
   word_t w_t;

   assign w_n1  = i_n[31:0];
   assign w_n2  = i_n[63:32];
   assign w_sum = w_n1 + i_k;

   // Row r of the table serves nibble r; entry v sits at 64*r + 4*v.
   always_comb begin
      w_sub = '0;
      for (int r = 0; r < 8; r++) begin
         w_sub[4*r +: 4] =
            i_sbox[64*r + 4*int'(w_sum[4*r +: 4]) +: 4];
      end
   end

   assign w_t = rol(w_sub) ^ w_n2;
   assign o_n = i_last ? {w_t, w_n1} : {w_n1, w_t};

endmodule

// File: rtl/gost89_cfb_decrypt.sv
// GOST 28147-89 CFB decryptor: P_i = C_i ^ E_K(C_{i-1}).
// One round per clock, 32 clocks per block, C_{-1} = IV.
module gost89_cfb_decrypt
   import gost89_pkg::*;
(
   input logic                 clk,
   input logic                 reset,
   gost89_cfb_decrypt_if.slave bus
);

   state_t r_state;
   state_t w_next;
   block_t r_n;
   block_t r_c;
   block_t r_fb;
   block_t r_out;
   logic   r_out_valid;
   rnd_t   r_rnd;

   block_t w_n;
   block_t w_seed;
   word_t  w_k;
   logic   w_idle;
   logic   w_start;
   logic   w_iv_ld;
   logic   w_last;
   logic   w_done;

   assign w_k = bus.key[{key_index(r_rnd), 5'd0} +: 32];

   gost89_round u_round (
      .i_n    (r_n),
      .i_k    (w_k),
      .i_sbox (bus.sbox),
      .i_last (w_last),
      .o_n    (w_n)
   );

   // A reset edge still honours the IDLE strobes, seeded from a cleared fb.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= bus.load_data ? S_RUN : S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (bus.load_data) w_next = S_RUN;
         S_RUN:  if (w_last)        w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_idle  = reset | (r_state == S_IDLE);
      w_start = bus.load_data & w_idle;
      w_iv_ld = bus.load_iv & w_idle;
      w_seed  = bus.load_iv ? bus.iv : (reset ? '0 : r_fb);
      w_last  = (r_rnd == LAST_RND);
      w_done  = ~reset & (r_state == S_RUN) & w_last;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_n         <= '0;
         r_c         <= '0;
         r_fb        <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_rnd       <= '0;
      end else begin
         r_out_valid <= w_done;
         if (r_state == S_RUN) begin
            r_n   <= w_n;
            r_rnd <= r_rnd + 5'd1;
            if (w_last) begin
               r_rnd <= '0;
               r_out <= w_n ^ r_c;
               r_fb  <= r_c;
            end
         end
      end
      if (w_iv_ld) begin
         r_fb <= bus.iv;
      end
      if (w_start) begin
         r_c   <= bus.in;
         r_n   <= w_seed;
         r_rnd <= '0;
      end
   end

   assign bus.busy      = (r_state == S_RUN);
   assign bus.out       = r_out;
   assign bus.out_valid = r_out_valid;

endmodule
